// File: rtl/conv_layer_sequencer_pkg.sv
// Shared types and per-layer constant tables for the conv layer sequencer.
// Table index is the layer number; entries are plain unsigned counts/sizes.
package conv_layer_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ADVANCE,
        FINISH
    } seq_state_t;

    localparam int MAX_LAYERS = 2;
    localparam int SEL_W      = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;
    localparam int CNT_W      = 8;
    localparam int TBL_W      = 16;

    localparam logic [TBL_W-1:0] IN_MAPS  [MAX_LAYERS] = '{16'd1,   16'd4};
    localparam logic [TBL_W-1:0] OUT_MAPS [MAX_LAYERS] = '{16'd4,   16'd2};
    localparam logic [TBL_W-1:0] IN_SIZE  [MAX_LAYERS] = '{16'd576, 16'd400};
    localparam logic [TBL_W-1:0] OUT_SIZE [MAX_LAYERS] = '{16'd400, 16'd256};

endpackage

// File: rtl/conv_loop_counter.sv
// Nested in/out/layer loop counters plus the map base-address multiply.
// in_idx is the innermost loop; every counter wraps to 0 after its last value.
module conv_loop_counter
    import conv_layer_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_LAYERS = 2,
    parameter int MUL_W      = 24
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  step,
    output logic [CNT_W-1:0]      layer,
    output logic                  first_in,
    output logic                  last_in,
    output logic                  last_pass,
    output logic [ADDR_WIDTH-1:0] in_addr,
    output logic [ADDR_WIDTH-1:0] out_addr
);

    logic [CNT_W-1:0] in_idx;
    logic [CNT_W-1:0] out_idx;
    logic [SEL_W-1:0] sel;
    logic             last_out;
    logic             last_layer;

    assign sel        = layer[SEL_W-1:0];
    assign first_in   = (in_idx == '0);
    assign last_in    = (TBL_W'(in_idx) == IN_MAPS[sel] - 16'd1);
    assign last_out   = (TBL_W'(out_idx) == OUT_MAPS[sel] - 16'd1);
    assign last_layer = (layer == CNT_W'(NUM_LAYERS - 1));
    assign last_pass  = last_in & last_out & last_layer;

    // Base addresses: index times map size, truncated to the address width
    assign in_addr  = ADDR_WIDTH'(MUL_W'(in_idx) * MUL_W'(IN_SIZE[sel]));
    assign out_addr = ADDR_WIDTH'(MUL_W'(out_idx) * MUL_W'(OUT_SIZE[sel]));

    // Step the loop nest one combination, or clear it on abort
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_idx  <= '0;
            out_idx <= '0;
            layer   <= '0;
        end else if (clear) begin
            in_idx  <= '0;
            out_idx <= '0;
            layer   <= '0;
        end else if (step) begin
            if (!last_in) begin
                in_idx <= in_idx + 1'b1;
            end else begin
                in_idx <= '0;
                if (!last_out) begin
                    out_idx <= out_idx + 1'b1;
                end else begin
                    out_idx <= '0;
                    layer   <= last_layer ? '0 : layer + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Conv layer sequencer: issues one conv engine pass per layer/out/in
// combination, waits for each to finish, and pulses done after the last.
module conv_layer_sequencer
    import conv_layer_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH            = 16,
    parameter int IN_FEATURE_ADDR_WIDTH = 10,
    parameter int NUM_LAYERS            = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             conv_done,
    output logic                             conv_start,
    output logic [IN_FEATURE_ADDR_WIDTH-1:0] conv_in_addr,
    output logic [IN_FEATURE_ADDR_WIDTH-1:0] conv_out_addr,
    output logic                             bank_sel,
    output logic                             acc_clear,
    output logic                             acc_write,
    output logic [7:0]                       layer_idx,
    output logic                             busy,
    output logic                             done
);

    seq_state_t       state;
    logic             armed;
    logic             running;
    logic             abort;
    logic             step;
    logic [CNT_W-1:0] layer;
    logic             first_in;
    logic             last_in;
    logic             last_pass;

    assign running = (state == ISSUE) || (state == WAIT) ||
                     (state == ADVANCE);
    assign abort   = running && !enable;
    assign step    = (state == ADVANCE) && enable;

    // The multiply runs in the datapath width widened by the counter width
    conv_loop_counter #(
        .ADDR_WIDTH (IN_FEATURE_ADDR_WIDTH),
        .NUM_LAYERS (NUM_LAYERS),
        .MUL_W      (DATA_WIDTH + CNT_W)
    ) u_loops (
        .clock     (clock),
        .reset     (reset),
        .clear     (abort),
        .step      (step),
        .layer     (layer),
        .first_in  (first_in),
        .last_in   (last_in),
        .last_pass (last_pass),
        .in_addr   (conv_in_addr),
        .out_addr  (conv_out_addr)
    );

    // Flags are only meaningful alongside the start pulse
    assign acc_clear = conv_start & first_in;
    assign acc_write = conv_start & last_in;
    assign layer_idx = layer;
    assign bank_sel  = layer[0];

    // Sequencer FSM with registered start/done/busy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            armed      <= 1'b1;
            conv_start <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            conv_start <= 1'b0;
            done       <= 1'b0;
            if (!enable) begin
                armed <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (enable && armed) begin
                        state      <= ISSUE;
                        conv_start <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (conv_done) begin
                        state <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (last_pass) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        state      <= ISSUE;
                        conv_start <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    armed <= !enable;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Bench for conv_layer_sequencer: a conv engine responder, a pass-list
// model built from the layer tables, and one per-cycle compare process.
module tb_conv_layer_sequencer;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       conv_done;
    logic       conv_start;
    logic [9:0] conv_in_addr;
    logic [9:0] conv_out_addr;
    logic       bank_sel;
    logic       acc_clear;
    logic       acc_write;
    logic [7:0] layer_idx;
    logic       busy;
    logic       done;

    logic eng_done;
    logic spur_idle;
    int   lat_mode;
    logic spur_issue;

    int n_cmp;
    int n_bad;
    int starts;
    int dones;
    int ptr;
    int cyc;
    int last_start_cyc;
    int total;

    logic [9:0] e_in    [16];
    logic [9:0] e_out   [16];
    logic [7:0] e_layer [16];
    logic       e_clr   [16];
    logic       e_wr    [16];

    logic [9:0] cap_in    [16];
    logic [9:0] cap_out   [16];
    logic [7:0] cap_layer [16];
    logic       cap_bank  [16];
    logic       cap_clr   [16];
    logic       cap_wr    [16];

    assign conv_done = eng_done | spur_idle;

    conv_layer_sequencer #(
        .DATA_WIDTH            (16),
        .IN_FEATURE_ADDR_WIDTH (10),
        .NUM_LAYERS            (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .conv_done     (conv_done),
        .conv_start    (conv_start),
        .conv_in_addr  (conv_in_addr),
        .conv_out_addr (conv_out_addr),
        .bank_sel      (bank_sel),
        .acc_clear     (acc_clear),
        .acc_write     (acc_write),
        .layer_idx     (layer_idx),
        .busy          (busy),
        .done          (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Conv engine: answer each start after a latency; optionally a stray
    // done pulse during the issue cycle, which must be ignored.
    initial begin
        int lat;
        eng_done = 1'b0;
        forever begin
            @(negedge clock);
            if (reset && conv_start) begin
                lat = (lat_mode != 0) ? lat_mode : int'($urandom_range(1, 6));
                eng_done = spur_issue && ($urandom_range(0, 1) == 1);
                @(negedge clock);
                eng_done = 1'b0;
                repeat (lat - 1) @(negedge clock);
                eng_done = 1'b1;
                @(negedge clock);
                eng_done = 1'b0;
            end
        end
    end

    // Compare process: every start must be the next pass of the model list
    always @(negedge clock) begin
        if (!reset) begin
            chk("reset_outputs",
                64'({conv_start, done, busy, acc_clear, acc_write, bank_sel,
                     conv_in_addr, conv_out_addr, layer_idx}), 64'(0));
            ptr = 0;
        end else begin
            if (conv_start) begin
                if (ptr >= total) begin
                    chk("start_beyond_run", 64'(ptr), 64'(total - 1));
                end else begin
                    chk($sformatf("pass%0d_fields", ptr),
                        64'({layer_idx, bank_sel, conv_in_addr, conv_out_addr,
                             acc_clear, acc_write}),
                        64'({e_layer[ptr], e_layer[ptr][0], e_in[ptr],
                             e_out[ptr], e_clr[ptr], e_wr[ptr]}));
                    if (lat_mode != 0 && ptr > 0)
                        chk("pass_gap", 64'(cyc - last_start_cyc),
                            64'(lat_mode + 2));
                    cap_in[ptr]    = conv_in_addr;
                    cap_out[ptr]   = conv_out_addr;
                    cap_layer[ptr] = layer_idx;
                    cap_bank[ptr]  = bank_sel;
                    cap_clr[ptr]   = acc_clear;
                    cap_wr[ptr]    = acc_write;
                end
                last_start_cyc = cyc;
                ptr++;
                starts++;
            end else begin
                chk("flags_without_start", 64'({acc_clear, acc_write}), 64'(0));
            end
            if (done) begin
                chk("done_after_all_passes", 64'(ptr), 64'(total));
                dones++;
            end
            if (!busy) ptr = 0;
        end
    end

    task automatic wait_done(input string name);
        int d0;
        int k;
        d0 = dones;
        k = 0;
        while (dones == d0 && k < 3000) begin
            @(negedge clock);
            k++;
        end
        chk(name, 64'(dones - d0), 64'(1));
    endtask

    task automatic wait_starts(input string name, input int base, input int n);
        int k;
        k = 0;
        while (starts - base < n && k < 2000) begin
            @(negedge clock);
            k++;
        end
        chk(name, 64'(starts - base >= n), 64'(1));
    endtask

    initial begin
        int tin  [2];
        int tout [2];
        int isz  [2];
        int osz  [2];
        int s0;
        int d0;

        tin  = '{1, 4};
        tout = '{4, 2};
        isz  = '{576, 400};
        osz  = '{400, 256};
        total = 0;
        for (int l = 0; l < 2; l++)
            for (int o = 0; o < tout[l]; o++)
                for (int i = 0; i < tin[l]; i++) begin
                    e_in[total]    = 10'((i * isz[l]) % 1024);
                    e_out[total]   = 10'((o * osz[l]) % 1024);
                    e_layer[total] = 8'(l);
                    e_clr[total]   = (i == 0);
                    e_wr[total]    = (i == tin[l] - 1);
                    total++;
                end

        n_cmp = 0;
        n_bad = 0;
        starts = 0;
        dones = 0;
        ptr = 0;
        cyc = 0;
        last_start_cyc = 0;
        reset = 1'b0;
        enable = 1'b1;
        spur_idle = 1'b0;
        spur_issue = 1'b0;
        lat_mode = 3;

        // Full run straight out of reset with enable already high
        repeat (3) @(negedge clock);
        chk("model_pass_count", 64'(total), 64'(12));
        s0 = starts;
        reset = 1'b1;
        wait_done("run1_done");
        chk("run1_starts", 64'(starts - s0), 64'(12));
        chk("run1_dones", 64'(dones), 64'(1));
        chk("l0_out_addr1", 64'(cap_out[1]), 64'(400));
        chk("l0_out_addr2", 64'(cap_out[2]), 64'(800));
        chk("l0_out_addr3", 64'(cap_out[3]), 64'(176));
        chk("l0_bank", 64'({cap_bank[0], cap_bank[1], cap_bank[2],
                            cap_bank[3]}), 64'(0));
        chk("l1_o1_i2", 64'({cap_in[10], cap_out[10], cap_bank[10],
                             cap_clr[10], cap_wr[10]}),
            64'({10'd800, 10'd256, 1'b1, 1'b0, 1'b0}));
        chk("l1_i3_write", 64'(cap_wr[11]), 64'(1));

        // Enable held high after done must not restart
        repeat (20) @(negedge clock);
        chk("no_restart_held", 64'(starts - s0), 64'(12));
        chk("idle_after_done", 64'(busy), 64'(0));

        // Stray conv_done in IDLE, both unarmed and armed
        spur_idle = 1'b1;
        @(negedge clock);
        spur_idle = 1'b0;
        enable = 1'b0;
        @(negedge clock);
        spur_idle = 1'b1;
        @(negedge clock);
        spur_idle = 1'b0;
        repeat (3) @(negedge clock);
        chk("spur_idle_busy", 64'(busy), 64'(0));
        chk("spur_idle_starts", 64'(starts - s0), 64'(12));

        // Restart, then abort while waiting on pass 5
        spur_issue = 1'b1;
        enable = 1'b1;
        s0 = starts;
        wait_starts("reach_pass5", s0, 5);
        @(negedge clock);
        enable = 1'b0;
        d0 = dones;
        @(negedge clock);
        chk("abort_busy", 64'(busy), 64'(0));
        repeat (12) @(negedge clock);
        chk("abort_no_done", 64'(dones - d0), 64'(0));
        s0 = starts;
        enable = 1'b1;
        wait_starts("restart_start", s0, 1);
        chk("restart_layer_addr", 64'({cap_layer[0], cap_in[0]}), 64'(0));
        wait_done("restart_done");
        spur_issue = 1'b0;

        // Randomised runs: random latency, stray dones, random aborts
        lat_mode = 0;
        for (int r = 0; r < 15; r++) begin
            enable = 1'b0;
            spur_issue = ($urandom_range(0, 1) == 1);
            repeat (12) @(negedge clock);
            enable = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(2, 60)) @(negedge clock);
                enable = 1'b0;
                repeat (2) @(negedge clock);
                chk("rand_abort_busy", 64'(busy), 64'(0));
            end else begin
                wait_done("rand_run_done");
            end
        end

        // Asynchronous reset while waiting in layer 1
        lat_mode = 6;
        spur_issue = 1'b0;
        enable = 1'b0;
        repeat (12) @(negedge clock);
        s0 = starts;
        enable = 1'b1;
        wait_starts("reach_layer1", s0, 7);
        @(negedge clock);
        chk("busy_in_wait", 64'(busy), 64'(1));
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outputs",
            64'({conv_start, done, busy, acc_clear, acc_write, bank_sel,
                 conv_in_addr, conv_out_addr, layer_idx}), 64'(0));
        enable = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (12) @(negedge clock);
        s0 = starts;
        enable = 1'b1;
        wait_starts("post_reset_start", s0, 1);
        chk("post_reset_layer", 64'({cap_layer[0], cap_in[0]}), 64'(0));
        wait_done("post_reset_done");

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "bench timeout");
    end

endmodule
